// File: rtl/instr_mem_arbiter.sv
// Single-port instruction memory sequencer: boot-time loader ownership, then
// fetch-priority arbitration with loader starvation protection and NOP-on-error fetches.
module instr_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 8
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              FetchReq,
  input  logic [31:0]       FetchAddr,
  output logic              FetchGnt,
  output logic              FetchValid,
  output logic [31:0]       FetchInstr,
  output logic              FetchErr,
  input  logic              LoadReq,
  input  logic              LoadWe,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [31:0]       LoadWData,
  input  logic              LoadDone,
  output logic              LoadGnt,
  output logic              LoadAck,
  output logic [31:0]       LoadRData,
  output logic              Stall,
  output logic              BootDone,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  input  logic [31:0]       MemRData
);

  localparam logic [0:0] ST_BOOT   = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic [1:0] TAG_NONE  = 2'd0;
  localparam logic [1:0] TAG_FETCH = 2'd1;
  localparam logic [1:0] TAG_LOAD  = 2'd2;
  localparam int         CNT_W     = $clog2(STARVE_MAX + 1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [1:0]        tag_q, tag_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [31:0]       fetch_instr_q, fetch_instr_d;
  logic [31:0]       load_rdata_q, load_rdata_d;
  logic              fetch_err, starved, fetch_gnt, load_gnt, stall;
  logic [ADDR_W-1:0] fetch_word;

  assign fetch_word = FetchAddr[ADDR_W+1:2];
  assign fetch_err  = (FetchAddr[1:0] != 2'b00) | ((FetchAddr >> (ADDR_W + 2)) != 32'd0);
  assign starved    = (starve_cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    stall     = 1'b1;
    state_d   = state_q;
    if (state_q == ST_BOOT) begin
      load_gnt = LoadReq;
      if (LoadDone) state_d = ST_RUN;
    end else begin
      // Fetch wins unless the loader has been refused STARVE_MAX cycles in a row.
      load_gnt  = LoadReq & (~FetchReq | starved);
      fetch_gnt = FetchReq & ~load_gnt;
      stall     = FetchReq & ~fetch_gnt;
    end

    starve_cnt_d = '0;
    if (LoadReq & ~load_gnt)
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + CNT_W'(1);

    tag_d = TAG_NONE;
    err_d = 1'b0;
    we_d  = 1'b0;
    if (fetch_gnt) begin
      tag_d = TAG_FETCH;
      err_d = fetch_err;
    end else if (load_gnt) begin
      tag_d = TAG_LOAD;
      we_d  = LoadWe;
    end

    MemEn    = (fetch_gnt & ~fetch_err) | load_gnt;
    MemWe    = load_gnt & LoadWe;
    MemAddr  = '0;
    MemWData = '0;
    if (load_gnt) begin
      MemAddr  = LoadAddr;
      MemWData = LoadWData;
    end else if (fetch_gnt) begin
      MemAddr = fetch_word;
    end

    // Response data bypasses MemRData in the ack cycle, then holds.
    fetch_instr_d = fetch_instr_q;
    if (tag_q == TAG_FETCH) fetch_instr_d = err_q ? 32'h0 : MemRData;
    load_rdata_d = load_rdata_q;
    if ((tag_q == TAG_LOAD) && !we_q) load_rdata_d = MemRData;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= ST_BOOT;
      starve_cnt_q  <= '0;
      tag_q         <= TAG_NONE;
      err_q         <= 1'b0;
      we_q          <= 1'b0;
      fetch_instr_q <= '0;
      load_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      tag_q         <= tag_d;
      err_q         <= err_d;
      we_q          <= we_d;
      fetch_instr_q <= fetch_instr_d;
      load_rdata_q  <= load_rdata_d;
    end
  end

  assign FetchGnt   = fetch_gnt;
  assign LoadGnt    = load_gnt;
  assign Stall      = stall;
  assign FetchValid = (tag_q == TAG_FETCH);
  assign FetchErr   = (tag_q == TAG_FETCH) & err_q;
  assign LoadAck    = (tag_q == TAG_LOAD);
  assign FetchInstr = fetch_instr_d;
  assign LoadRData  = load_rdata_d;
  assign BootDone   = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: per-cycle vector table plus
// starvation and mid-fetch reset sequences against a small synchronous RAM model.
module tb_instr_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam logic [31:0] D1 = 32'h20080001;
  localparam logic [31:0] D2 = 32'h20080002;
  localparam logic [31:0] D3 = 32'h20080003;
  localparam logic [31:0] D4 = 32'h20080004;
  localparam logic [31:0] BEEF = 32'hDEADBEEF;

  logic              Clk = 1'b0;
  logic              ResetN;
  logic              FetchReq;
  logic [31:0]       FetchAddr;
  logic              FetchGnt, FetchValid, FetchErr;
  logic [31:0]       FetchInstr;
  logic              LoadReq, LoadWe, LoadDone;
  logic [ADDR_W-1:0] LoadAddr;
  logic [31:0]       LoadWData;
  logic              LoadGnt, LoadAck;
  logic [31:0]       LoadRData;
  logic              Stall, BootDone, MemEn, MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWData, MemRData;

  int checks = 0;
  int errors = 0;

  instr_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchGnt(FetchGnt),
    .FetchValid(FetchValid), .FetchInstr(FetchInstr), .FetchErr(FetchErr),
    .LoadReq(LoadReq), .LoadWe(LoadWe), .LoadAddr(LoadAddr), .LoadWData(LoadWData),
    .LoadDone(LoadDone), .LoadGnt(LoadGnt), .LoadAck(LoadAck), .LoadRData(LoadRData),
    .Stall(Stall), .BootDone(BootDone), .MemEn(MemEn), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    MemRData = 32'h0;
  end
  always @(posedge Clk) begin
    if (MemEn && MemWe) mem[MemAddr] <= MemWData;
    else if (MemEn) MemRData <= mem[MemAddr];
  end

  typedef struct {
    logic        freq;
    logic [31:0] faddr;
    logic        lreq, lwe, ldone;
    logic [9:0]  laddr;
    logic [31:0] lwdata;
    logic        fgnt, lgnt, stall, memen, memwe, fvalid, ferr, lack, bootdone;
    logic [9:0]  memaddr;
    logic [31:0] finstr, lrdata;
  } vec_t;

  vec_t tbl [20];

  // in_fl = {freq, lreq, lwe, ldone}; ex_fl = {fgnt, lgnt, stall, memen, memwe, fvalid, ferr, lack, bootdone}
  function automatic vec_t mk(input logic [3:0] in_fl, input logic [31:0] faddr,
                              input int laddr, input logic [31:0] lwdata,
                              input logic [8:0] ex_fl, input int memaddr,
                              input logic [31:0] finstr, input logic [31:0] lrdata);
    vec_t v;
    v.freq = in_fl[3]; v.lreq = in_fl[2]; v.lwe = in_fl[1]; v.ldone = in_fl[0];
    v.faddr = faddr; v.laddr = 10'(laddr); v.lwdata = lwdata;
    v.fgnt = ex_fl[8]; v.lgnt = ex_fl[7]; v.stall = ex_fl[6]; v.memen = ex_fl[5];
    v.memwe = ex_fl[4]; v.fvalid = ex_fl[3]; v.ferr = ex_fl[2]; v.lack = ex_fl[1];
    v.bootdone = ex_fl[0];
    v.memaddr = 10'(memaddr); v.finstr = finstr; v.lrdata = lrdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " FetchGnt"}, 32'(FetchGnt), 0);
    chk({tag, " FetchValid"}, 32'(FetchValid), 0);
    chk({tag, " FetchInstr"}, FetchInstr, 0);
    chk({tag, " FetchErr"}, 32'(FetchErr), 0);
    chk({tag, " LoadGnt"}, 32'(LoadGnt), 0);
    chk({tag, " LoadAck"}, 32'(LoadAck), 0);
    chk({tag, " LoadRData"}, LoadRData, 0);
    chk({tag, " Stall"}, 32'(Stall), 1);
    chk({tag, " BootDone"}, 32'(BootDone), 0);
    chk({tag, " MemEn"}, 32'(MemEn), 0);
    chk({tag, " MemWe"}, 32'(MemWe), 0);
    chk({tag, " MemAddr"}, 32'(MemAddr), 0);
    chk({tag, " MemWData"}, MemWData, 0);
    chk({tag, " StarveCnt"}, 32'(dut.starve_cnt_q), 0);
    chk({tag, " state"}, 32'(dut.state_q), 0);
  endtask

  initial begin
    tbl[0]  = mk(4'b0110, 0,     0, D1,   9'b011110000, 0, 0,  0);
    tbl[1]  = mk(4'b1000, 0,     0, 0,    9'b001000010, 0, 0,  0);
    tbl[2]  = mk(4'b1110, 0,     1, D2,   9'b011110000, 1, 0,  0);
    tbl[3]  = mk(4'b0110, 0,     2, D3,   9'b011110010, 2, 0,  0);
    tbl[4]  = mk(4'b0111, 0,     3, D4,   9'b011110010, 3, 0,  0);
    tbl[5]  = mk(4'b1000, 0,     0, 0,    9'b100100011, 0, 0,  0);
    tbl[6]  = mk(4'b1000, 4,     0, 0,    9'b100101001, 1, D1, 0);
    tbl[7]  = mk(4'b1000, 8,     0, 0,    9'b100101001, 2, D2, 0);
    tbl[8]  = mk(4'b1000, 'hC,   0, 0,    9'b100101001, 3, D3, 0);
    tbl[9]  = mk(4'b0000, 0,     0, 0,    9'b000001001, 0, D4, 0);
    tbl[10] = mk(4'b0000, 0,     0, 0,    9'b000000001, 0, D4, 0);
    tbl[11] = mk(4'b1000, 2,     0, 0,    9'b100000001, 0, D4, 0);
    tbl[12] = mk(4'b1000, 'h1000,0, 0,    9'b100001101, 0, 0,  0);
    tbl[13] = mk(4'b0000, 0,     0, 0,    9'b000001101, 0, 0,  0);
    tbl[14] = mk(4'b1001, 0,     0, 0,    9'b100100001, 0, 0,  0);
    tbl[15] = mk(4'b0110, 0,     5, BEEF, 9'b010111001, 5, D1, 0);
    tbl[16] = mk(4'b0100, 0,     5, 0,    9'b010100011, 5, D1, 0);
    tbl[17] = mk(4'b0000, 0,     0, 0,    9'b000000011, 0, D1, BEEF);
    tbl[18] = mk(4'b1100, 4,     5, 0,    9'b100100001, 1, D1, BEEF);
    tbl[19] = mk(4'b0000, 0,     0, 0,    9'b000001001, 0, D2, BEEF);

    ResetN = 1'b0; FetchReq = 1'b0; FetchAddr = 32'h0; LoadReq = 1'b0; LoadWe = 1'b0;
    LoadAddr = '0; LoadWData = 32'h0; LoadDone = 1'b0;
    repeat (2) @(negedge Clk);
    #1 chk_reset("reset");
    @(negedge Clk) ResetN = 1'b1;

    for (int r = 0; r < 20; r++) begin
      @(negedge Clk);
      FetchReq = tbl[r].freq; FetchAddr = tbl[r].faddr; LoadReq = tbl[r].lreq;
      LoadWe = tbl[r].lwe; LoadAddr = tbl[r].laddr; LoadWData = tbl[r].lwdata;
      LoadDone = tbl[r].ldone;
      #1;
      chk($sformatf("row%0d FetchGnt", r), 32'(FetchGnt), 32'(tbl[r].fgnt));
      chk($sformatf("row%0d LoadGnt", r), 32'(LoadGnt), 32'(tbl[r].lgnt));
      chk($sformatf("row%0d Stall", r), 32'(Stall), 32'(tbl[r].stall));
      chk($sformatf("row%0d MemEn", r), 32'(MemEn), 32'(tbl[r].memen));
      chk($sformatf("row%0d MemWe", r), 32'(MemWe), 32'(tbl[r].memwe));
      chk($sformatf("row%0d MemAddr", r), 32'(MemAddr), 32'(tbl[r].memaddr));
      chk($sformatf("row%0d FetchValid", r), 32'(FetchValid), 32'(tbl[r].fvalid));
      chk($sformatf("row%0d FetchErr", r), 32'(FetchErr), 32'(tbl[r].ferr));
      chk($sformatf("row%0d FetchInstr", r), FetchInstr, tbl[r].finstr);
      chk($sformatf("row%0d LoadAck", r), 32'(LoadAck), 32'(tbl[r].lack));
      chk($sformatf("row%0d LoadRData", r), LoadRData, tbl[r].lrdata);
      chk($sformatf("row%0d BootDone", r), 32'(BootDone), 32'(tbl[r].bootdone));
    end

    // Starvation: fetch and load both held; load breaks through on cycle 9.
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      FetchReq = 1'b1; FetchAddr = 32'h0; LoadReq = (c <= 9); LoadWe = 1'b0;
      LoadAddr = 10'd5; LoadWData = 32'h0; LoadDone = 1'b0;
      #1;
      if (c <= 8) begin
        chk($sformatf("starve c%0d FetchGnt", c), 32'(FetchGnt), 1);
        chk($sformatf("starve c%0d LoadGnt", c), 32'(LoadGnt), 0);
      end else if (c == 9) begin
        chk("starve c9 LoadGnt", 32'(LoadGnt), 1);
        chk("starve c9 FetchGnt", 32'(FetchGnt), 0);
        chk("starve c9 Stall", 32'(Stall), 1);
        chk("starve c9 MemAddr", 32'(MemAddr), 5);
      end else begin
        chk("starve c10 LoadAck", 32'(LoadAck), 1);
        chk("starve c10 LoadRData", LoadRData, BEEF);
        chk("starve c10 StarveCnt", 32'(dut.starve_cnt_q), 0);
        chk("starve c10 FetchGnt", 32'(FetchGnt), 1);
      end
    end

    // Reset asserted in the same cycle a fetch is granted.
    @(negedge Clk);
    FetchReq = 1'b1; FetchAddr = 32'h8; LoadReq = 1'b0;
    #1 chk("midrst FetchGnt before", 32'(FetchGnt), 1);
    #2 ResetN = 1'b0;
    #1 chk_reset("midrst");
    FetchReq = 1'b0; FetchAddr = 32'h0;
    @(negedge Clk);
    #1 chk("midrst held FetchValid", 32'(FetchValid), 0);
    @(negedge Clk) ResetN = 1'b1;
    @(negedge Clk);
    #1;
    chk("midrst after FetchValid", 32'(FetchValid), 0);
    chk("midrst after LoadAck", 32'(LoadAck), 0);
    chk("midrst after Stall", 32'(Stall), 1);
    chk("midrst after BootDone", 32'(BootDone), 0);
    chk("midrst after state", 32'(dut.state_q), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
